ks_mw_add_seq: RTL and testbench



---
 rtl/ks_mw_add_seq_pkg.sv | 15 +
 rtl/ks_mw_add_seq_if.sv | 37 +++
 rtl/ks_adder.sv | 33 +++
 rtl/ks_mw_add_seq.sv | 131 +++++++++++++
 tb/tb_ks_mw_add_seq.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ks_mw_add_seq_pkg.sv
// Shared types for the multi-word add/subtract sequencer (package ks_pkg).
package ks_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ks_seq_state_t;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } ks_op_t;

endpackage

// File: rtl/ks_mw_add_seq_if.sv
// Request/response bundle for ks_mw_add_seq; resp_ovf exists only under KS_MW_OVF_EN.
// Handshake: a transfer happens on a rising edge where valid && ready; the source
// holds valid and its payload stable until that edge, and ready never depends on valid.
interface ks_mw_add_seq_if #(
   parameter int SIZE  = 64,
   parameter int WORDS = 4
);
   logic                    req_valid;
   logic                    req_ready;
   logic [SIZE*WORDS-1:0]   req_a;
   logic [SIZE*WORDS-1:0]   req_b;
   logic                    req_sub;
   logic                    req_cin;
   logic                    resp_valid;
   logic                    resp_ready;
   logic [SIZE*WORDS-1:0]   resp_result;
   logic                    resp_cout;
`ifdef KS_MW_OVF_EN
   logic                    resp_ovf;
`endif

   modport master (
      output req_valid, req_a, req_b, req_sub, req_cin, resp_ready,
`ifdef KS_MW_OVF_EN
      input  resp_ovf,
`endif
      input  req_ready, resp_valid, resp_result, resp_cout
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sub, req_cin, resp_ready,
`ifdef KS_MW_OVF_EN
      output resp_ovf,
`endif
      output req_ready, resp_valid, resp_result, resp_cout
   );
endinterface

// File: rtl/ks_adder.sv
// Combinational Kogge-Stone adder: result = a + b + c_in, c_out = carry out of the top bit.
module ks_adder #(
   parameter int SIZE = 64
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            c_in,
   output logic [SIZE-1:0] result,
   output logic            c_out
);
   localparam int LV = $clog2(SIZE);

   logic [SIZE-1:0] p0;
   logic [SIZE-1:0] g0;
   logic [SIZE-1:0] g;
   logic [SIZE-1:0] p;

   // c_in is folded into bit 0's generate so g[i] becomes the carry out of bit i.
   always_comb begin
      p0    = a ^ b;
      g0    = a & b;
      g0[0] = g0[0] | (p0[0] & c_in);
      g     = g0;
      p     = p0;
      for (int l = 0; l < LV; l++) begin
         g = g | (p & (g << (1 << l)));
         p = p & ~((~p) << (1 << l));
      end
   end

   assign result = p0 ^ {g[SIZE-2:0], c_in};
   assign c_out  = g[SIZE-1];
endmodule

// File: rtl/ks_mw_add_seq.sv
// Multi-word add/subtract sequencer: one SIZE-bit chunk per cycle through a shared ks_adder.
// Optional signed-overflow output is enabled with KS_MW_OVF_EN.
module ks_mw_add_seq
   import ks_pkg::*;
#(
   parameter int SIZE  = 64,
   parameter int WORDS = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   ks_mw_add_seq_if.slave  bus,
   output ks_seq_state_t   dbg_state
);
   localparam int W        = SIZE * WORDS;
   localparam int KS_IDX_W = $clog2(WORDS);

   ks_seq_state_t         state_q, state_d;
   logic [KS_IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]          a_q, a_d;
   logic [W-1:0]          bx_q, bx_d;
   logic [W-1:0]          res_q, res_d;
   ks_op_t                op_q, op_d;
   logic                  cy_q, cy_d;
   logic                  cout_q, cout_d;
   logic                  rdy_q, rdy_d;
`ifdef KS_MW_OVF_EN
   logic                  ovf_q, ovf_d;
`endif

   logic [SIZE-1:0]       a_chunk;
   logic [SIZE-1:0]       bx_chunk;
   logic [SIZE-1:0]       sum;
   logic                  c_out;
   logic                  last;

   assign a_chunk  = a_q[int'(idx_q)*SIZE +: SIZE];
   assign bx_chunk = bx_q[int'(idx_q)*SIZE +: SIZE];
   assign last     = (idx_q == KS_IDX_W'(WORDS-1));

   ks_adder #(.SIZE(SIZE)) u_add (
      .a      (a_chunk),
      .b      (bx_chunk),
      .c_in   (cy_q),
      .result (sum),
      .c_out  (c_out)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      bx_d    = bx_q;
      res_d   = res_q;
      op_d    = op_q;
      cy_d    = cy_q;
      cout_d  = cout_q;
`ifdef KS_MW_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            // Subtraction is A + ~B + 1; the +1 rides in on the initial carry.
            if (bus.req_valid && rdy_q) begin
               a_d     = bus.req_a;
               bx_d    = bus.req_sub ? ~bus.req_b : bus.req_b;
               op_d    = ks_op_t'(bus.req_sub);
               cy_d    = bus.req_cin ^ bus.req_sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[int'(idx_q)*SIZE +: SIZE] = sum;
            cy_d  = c_out;
            idx_d = idx_q + 1'b1;
            if (last) begin
               idx_d   = '0;
               cout_d  = c_out ^ (op_q == SUB);
`ifdef KS_MW_OVF_EN
               ovf_d   = (a_chunk[SIZE-1] ~^ bx_chunk[SIZE-1]) & (a_chunk[SIZE-1] ^ sum[SIZE-1]);
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         bx_q    <= '0;
         res_q   <= '0;
         op_q    <= ADD;
         cy_q    <= 1'b0;
         cout_q  <= 1'b0;
         rdy_q   <= 1'b0;
`ifdef KS_MW_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         bx_q    <= bx_d;
         res_q   <= res_d;
         op_q    <= op_d;
         cy_q    <= cy_d;
         cout_q  <= cout_d;
         rdy_q   <= rdy_d;
`ifdef KS_MW_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign bus.req_ready   = rdy_q;
   assign bus.resp_valid  = (state_q == DONE);
   assign bus.resp_result = res_q;
   assign bus.resp_cout   = cout_q;
`ifdef KS_MW_OVF_EN
   assign bus.resp_ovf    = ovf_q;
`endif
   assign dbg_state       = state_q;
endmodule

// File: tb/tb_ks_mw_add_seq.sv
// Directed bench for ks_mw_add_seq (SIZE=64, WORDS=4); overflow checks only under KS_MW_OVF_EN.
module tb_ks_mw_add_seq;
   import ks_pkg::*;

   localparam int SIZE  = 64;
   localparam int WORDS = 4;
   localparam int W     = SIZE * WORDS;

   logic          clk = 1'b0;
   logic          rst_n;
   ks_seq_state_t dbg_state;
   int            n_cmp  = 0;
   int            n_fail = 0;

   ks_mw_add_seq_if #(.SIZE(SIZE), .WORDS(WORDS)) bus ();

   ks_mw_add_seq #(.SIZE(SIZE), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_sub   = sub;
      bus.req_cin   = cin;
      bus.req_valid = 1'b1;
   endtask

   task automatic wait_accept(input string tag);
      int n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_accept"}, W'(bus.req_ready), W'(1));
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      while (!bus.resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_resp();
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic cin, input int stall,
                           input logic [W-1:0] e_res, input logic e_cout, input logic e_ovf);
      int lat;
      drive_req(a, b, sub, cin);
      wait_accept(tag);
      wait_resp(lat);
      chk({tag, "_lat"}, W'(lat), W'(WORDS));
      repeat (stall) @(negedge clk);
      chk({tag, "_res"}, bus.resp_result, e_res);
      chk({tag, "_cout"}, W'(bus.resp_cout), W'(e_cout));
`ifdef KS_MW_OVF_EN
      chk({tag, "_ovf"}, W'(bus.resp_ovf), W'(e_ovf));
`endif
      release_resp();
   endtask

   initial begin
      logic [W-1:0] ones;
      logic [W-1:0] max_pos;
      logic [W-1:0] min_neg;
      logic [W-1:0] ra, rb;
      logic [W:0]   full;
      logic         rs, rc, rov;
      int           lat;

      ones    = '1;
      max_pos = {1'b0, {(W-1){1'b1}}};
      min_neg = {1'b1, {(W-1){1'b0}}};

      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_sub    = 1'b0;
      bus.req_cin    = 1'b0;
      bus.resp_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready", W'(bus.req_ready), W'(0));
      chk("rst_resp_valid", W'(bus.resp_valid), W'(0));
      chk("rst_resp_result", bus.resp_result, W'(0));
      chk("rst_resp_cout", W'(bus.resp_cout), W'(0));
      chk("rst_state", W'(dbg_state), W'(IDLE));
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_req_ready", W'(bus.req_ready), W'(1));

      // Full carry chain and borrow cases
      check_op("add_chain", ones, W'(1), 1'b0, 1'b0, 0, W'(0), 1'b1, 1'b0);
      check_op("sub_borrow", W'(5), W'(7), 1'b1, 1'b0, 1, ones - W'(1), 1'b1, 1'b0);
      check_op("sub_pos", W'(7), W'(5), 1'b1, 1'b0, 0, W'(2), 1'b0, 1'b0);
      check_op("sub_bin", W'(7), W'(5), 1'b1, 1'b1, 0, W'(1), 1'b0, 1'b0);
      check_op("add_cin", W'(0), W'(0), 1'b0, 1'b1, 2, W'(1), 1'b0, 1'b0);
      check_op("ovf_add", max_pos, W'(1), 1'b0, 1'b0, 0, min_neg, 1'b0, 1'b1);
      check_op("ovf_sub", min_neg, W'(1), 1'b1, 1'b0, 0, max_pos, 1'b0, 1'b1);
      check_op("no_ovf", W'(3), W'(4), 1'b0, 1'b0, 0, W'(7), 1'b0, 1'b0);

      // Backpressure: result held and a pending request ignored while in DONE
      drive_req(W'(123), W'(456), 1'b0, 1'b0);
      wait_accept("bp1");
      wait_resp(lat);
      chk("bp1_lat", W'(lat), W'(WORDS));
      drive_req(W'(1000), W'(1), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", W'(bus.resp_valid), W'(1));
         chk("bp_result", bus.resp_result, W'(579));
         chk("bp_req_ready", W'(bus.req_ready), W'(0));
         chk("bp_state", W'(dbg_state), W'(DONE));
      end
      release_resp();
      chk("bp_idle_state", W'(dbg_state), W'(IDLE));
      chk("bp_idle_ready", W'(bus.req_ready), W'(1));
      wait_accept("bp2");
      chk("bp2_state", W'(dbg_state), W'(RUN));
      wait_resp(lat);
      chk("bp2_lat", W'(lat), W'(WORDS));
      chk("bp2_result", bus.resp_result, W'(999));
      chk("bp2_cout", W'(bus.resp_cout), W'(0));
      release_resp();

      // Reset in the middle of RUN at idx=2
      drive_req(ones, W'(1), 1'b0, 1'b0);
      wait_accept("mid_rst");
      @(negedge clk);
      @(negedge clk);
      chk("mid_rst_run", W'(dbg_state), W'(RUN));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", W'(bus.resp_valid), W'(0));
      chk("mid_rst_result", bus.resp_result, W'(0));
      chk("mid_rst_ready", W'(bus.req_ready), W'(0));
      chk("mid_rst_cout", W'(bus.resp_cout), W'(0));
      @(negedge clk);
      chk("mid_rst_ready2", W'(bus.req_ready), W'(0));
      chk("mid_rst_state", W'(dbg_state), W'(IDLE));
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("after_rst_ready", W'(bus.req_ready), W'(1));
      chk("after_rst_valid", W'(bus.resp_valid), W'(0));
      check_op("after_rst_op", W'(7), W'(5), 1'b1, 1'b0, 0, W'(2), 1'b0, 1'b0);

      // Random operands against a 257-bit reference
      for (int n = 0; n < 60; n++) begin
         for (int k = 0; k < W / 32; k++) begin
            ra = {ra[W-33:0], 32'($urandom())};
            rb = {rb[W-33:0], 32'($urandom())};
         end
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         if (rs) full = {1'b0, ra} - {1'b0, rb} - (W+1)'(rc);
         else    full = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
         if (rs) rov = (ra[W-1] != rb[W-1]) && (full[W-1] != ra[W-1]);
         else    rov = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
         check_op("rand", ra, rb, rs, rc, $urandom_range(0, 3), full[W-1:0], full[W], rov);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
